// File: rtl/imm_pkg.sv
// Shared definitions for the A/S immediate and mask generator: opcode values,
// parcel field positions and the two-parcel FSM state encoding.
package imm_pkg;

   localparam logic [6:0] OP_AI_JKM  = 7'o020;
   localparam logic [6:0] OP_AI_NJKM = 7'o021;
   localparam logic [6:0] OP_AI_JK   = 7'o022;
   localparam logic [6:0] OP_AI_SJ   = 7'o023;
   localparam logic [6:0] OP_SI_JKM  = 7'o040;
   localparam logic [6:0] OP_SI_NJKM = 7'o041;
   localparam logic [6:0] OP_MASK_R  = 7'o042;
   localparam logic [6:0] OP_MASK_L  = 7'o043;

   localparam int OP_MSB = 15;
   localparam int OP_LSB = 9;
   localparam int I_MSB  = 8;
   localparam int I_LSB  = 6;
   localparam int J_MSB  = 5;
   localparam int J_LSB  = 3;
   localparam int K_MSB  = 2;
   localparam int K_LSB  = 0;

   typedef enum logic {
      IDLE   = 1'b0,
      WAIT_M = 1'b1
   } state_t;

   // The jkm forms need a second parcel carrying m.
   function automatic logic isTwoParcel(input logic [6:0] op);
      return (op == OP_AI_JKM) || (op == OP_AI_NJKM) ||
             (op == OP_SI_JKM) || (op == OP_SI_NJKM);
   endfunction

endpackage

// File: rtl/imm_mask_unit.sv
// S-register mask former: right-justified ones (S_WIDTH-jk of them) or
// left-justified ones (jk of them), selected by i_left.
module imm_mask_unit #(
   parameter int S_WIDTH = 64
) (
   input  logic [5:0]         i_jk,
   input  logic               i_left,
   output logic [S_WIDTH-1:0] o_mask
);

   logic [S_WIDTH-1:0] w_right;

   // The left mask is exactly the complement of the right mask for the same jk.
   always_comb begin
      w_right = {S_WIDTH{1'b1}} >> i_jk;
      o_mask  = i_left ? ~w_right : w_right;
   end

endmodule

// File: rtl/imm_mask_gen.sv
// A/S immediate and mask generator. Assembles two-parcel jkm instructions,
// decodes one result per instruction into a backpressured output register.
// Optional macro IMM_MASK_EN enables the 042/043 mask forms; without it
// those opcodes are reported as illegal.
module imm_mask_gen
   import imm_pkg::*;
#(
   parameter int A_WIDTH  = 24,
   parameter int S_WIDTH  = 64,
   parameter int PARCEL_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_p_vld,
   input  logic [PARCEL_W-1:0] i_parcel,
   output logic                o_p_rdy,
   input  logic [S_WIDTH-1:0]  i_sj,
   input  logic                i_flush,
   output logic                o_vld,
   input  logic                i_rdy,
   output logic                o_dst_s,
   output logic [2:0]          o_dst_i,
   output logic [A_WIDTH-1:0]  o_a_result,
   output logic [S_WIDTH-1:0]  o_s_result,
   output logic                o_ill
);

   localparam int JKM_W = 6 + PARCEL_W;

   state_t r_state, w_nextState;
   logic [6:0] r_op;
   logic [2:0] r_i, r_j, r_k;

   logic [6:0] w_pOp;
   logic [2:0] w_pI, w_pJ, w_pK;
   logic       w_accept;
   logic       w_load, w_latch;
   logic [6:0] w_op;
   logic [2:0] w_i, w_j, w_k;
   logic [JKM_W-1:0]   w_jkm;
   logic [A_WIDTH-1:0] w_aRes;
   logic [S_WIDTH-1:0] w_sRes;
   logic w_dstS, w_ill;
   logic w_unusedSj;

   logic r_vld, r_dstS, r_ill;
   logic [2:0] r_dstI;
   logic [A_WIDTH-1:0] r_aResult;
   logic [S_WIDTH-1:0] r_sResult;

   assign w_pOp = i_parcel[OP_MSB:OP_LSB];
   assign w_pI  = i_parcel[I_MSB:I_LSB];
   assign w_pJ  = i_parcel[J_MSB:J_LSB];
   assign w_pK  = i_parcel[K_MSB:K_LSB];
   assign w_unusedSj = ^i_sj[S_WIDTH-1:A_WIDTH];

   assign o_p_rdy  = !r_vld | i_rdy;
   assign w_accept = i_p_vld & o_p_rdy & !i_flush;

   // State register; reset abandons any half-assembled instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_nextState;
   end

   // Next state: a two-parcel opcode waits for m; flush always returns to IDLE.
   always_comb begin
      w_nextState = r_state;
      if (i_flush) begin
         w_nextState = IDLE;
      end else if (w_accept) begin
         if (r_state == IDLE) w_nextState = isTwoParcel(w_pOp) ? WAIT_M : IDLE;
         else                 w_nextState = IDLE;
      end
   end

   // Control outputs and operand selection: in WAIT_M the latched fields are
   // decoded and the incoming parcel is purely the m field.
   always_comb begin
      w_latch = 1'b0;
      w_load  = 1'b0;
      w_op    = w_pOp;
      w_i     = w_pI;
      w_j     = w_pJ;
      w_k     = w_pK;
      if (r_state == WAIT_M) begin
         w_op   = r_op;
         w_i    = r_i;
         w_j    = r_j;
         w_k    = r_k;
         w_load = w_accept;
      end else if (w_accept) begin
         w_latch = isTwoParcel(w_pOp);
         w_load  = !isTwoParcel(w_pOp);
      end
      w_jkm = {w_j, w_k, i_parcel};
   end

`ifdef IMM_MASK_EN
   logic [S_WIDTH-1:0] w_mask;

   imm_mask_unit #(.S_WIDTH(S_WIDTH)) u_maskUnit (
      .i_jk   ({w_j, w_k}),
      .i_left (w_op == OP_MASK_L),
      .o_mask (w_mask)
   );
`endif

   // Result decode; the bus for the other register file stays zero.
   always_comb begin
      w_aRes = '0;
      w_sRes = '0;
      w_dstS = 1'b0;
      w_ill  = 1'b0;
      case (w_op)
         OP_AI_JKM:  w_aRes = A_WIDTH'(w_jkm);
         OP_AI_NJKM: w_aRes = ~A_WIDTH'(w_jkm);
         OP_AI_JK:   w_aRes = A_WIDTH'({w_j, w_k});
         OP_AI_SJ:   w_aRes = i_sj[A_WIDTH-1:0];
         OP_SI_JKM: begin
            w_sRes = S_WIDTH'(w_jkm);
            w_dstS = 1'b1;
         end
         OP_SI_NJKM: begin
            w_sRes = ~S_WIDTH'(w_jkm);
            w_dstS = 1'b1;
         end
`ifdef IMM_MASK_EN
         OP_MASK_R, OP_MASK_L: begin
            w_sRes = w_mask;
            w_dstS = 1'b1;
         end
`else
         OP_MASK_R, OP_MASK_L: w_ill = 1'b1;
`endif
         default: w_ill = 1'b1;
      endcase
   end

   // Holding register for the first parcel of a jkm instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op <= '0;
         r_i  <= '0;
         r_j  <= '0;
         r_k  <= '0;
      end else if (w_latch) begin
         r_op <= w_pOp;
         r_i  <= w_pI;
         r_j  <= w_pJ;
         r_k  <= w_pK;
      end
   end

   // Output register: flush drops it, a load replaces it, a drain clears valid,
   // otherwise everything holds under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld     <= 1'b0;
         r_dstS    <= 1'b0;
         r_dstI    <= '0;
         r_aResult <= '0;
         r_sResult <= '0;
         r_ill     <= 1'b0;
      end else if (i_flush) begin
         r_vld <= 1'b0;
      end else if (w_load) begin
         r_vld     <= 1'b1;
         r_dstS    <= w_dstS;
         r_dstI    <= w_i;
         r_aResult <= w_aRes;
         r_sResult <= w_sRes;
         r_ill     <= w_ill;
      end else if (r_vld && i_rdy) begin
         r_vld <= 1'b0;
      end
   end

   assign o_vld      = r_vld;
   assign o_dst_s    = r_dstS;
   assign o_dst_i    = r_dstI;
   assign o_a_result = r_aResult;
   assign o_s_result = r_sResult;
   assign o_ill      = r_ill;

endmodule

// File: tb/tb_imm_mask_gen.sv
// Directed self-checking bench for imm_mask_gen (default parameters).
// Mask expectations follow IMM_MASK_EN when the bench is built with it.
module tb_imm_mask_gen;

   logic        clk;
   logic        rst_n;
   logic        i_p_vld;
   logic [15:0] i_parcel;
   logic        o_p_rdy;
   logic [63:0] i_sj;
   logic        i_flush;
   logic        o_vld;
   logic        i_rdy;
   logic        o_dst_s;
   logic [2:0]  o_dst_i;
   logic [23:0] o_a_result;
   logic [63:0] o_s_result;
   logic        o_ill;

   int nChecks = 0;
   int nFail   = 0;

   imm_mask_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_p_vld    (i_p_vld),
      .i_parcel   (i_parcel),
      .o_p_rdy    (o_p_rdy),
      .i_sj       (i_sj),
      .i_flush    (i_flush),
      .o_vld      (o_vld),
      .i_rdy      (i_rdy),
      .o_dst_s    (o_dst_s),
      .o_dst_i    (o_dst_i),
      .o_a_result (o_a_result),
      .o_s_result (o_s_result),
      .o_ill      (o_ill)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mkParcel(input logic [6:0] op, input logic [2:0] i,
                                            input logic [2:0] j, input logic [2:0] k);
      return {op, i, j, k};
   endfunction

   // Present one parcel for exactly one clock edge, then withdraw it.
   task automatic applyStimulus(input logic [15:0] p, input logic [63:0] sj);
      i_p_vld  = 1'b1;
      i_parcel = p;
      i_sj     = sj;
      @(posedge clk);
      #1;
      i_p_vld  = 1'b0;
   endtask

   task automatic stepIdle();
      @(posedge clk);
      #1;
   endtask

   // Compare the whole result bundle {vld, dst_s, dst_i, a, s, ill} at once.
   task automatic checkOutput(input string tag, input logic vld, input logic dstS,
                              input logic [2:0] dstI, input logic [23:0] a,
                              input logic [63:0] s, input logic ill);
      logic [93:0] obs, expv;
      obs  = {o_vld, o_dst_s, o_dst_i, o_a_result, o_s_result, o_ill};
      expv = {vld, dstS, dstI, a, s, ill};
      nChecks++;
      assert (obs === expv) else begin
         nFail++;
         $error("[TB] FAIL %s observed vld=%b dst_s=%b dst_i=%0d a=%h s=%h ill=%b expected vld=%b dst_s=%b dst_i=%0d a=%h s=%h ill=%b",
                tag, o_vld, o_dst_s, o_dst_i, o_a_result, o_s_result, o_ill,
                vld, dstS, dstI, a, s, ill);
      end
   endtask

   task automatic checkRdy(input string tag, input logic expRdy);
      nChecks++;
      assert (o_p_rdy === expRdy) else begin
         nFail++;
         $error("[TB] FAIL %s observed o_p_rdy=%b expected %b", tag, o_p_rdy, expRdy);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      i_p_vld  = 1'b0;
      i_parcel = '0;
      i_sj     = '0;
      i_flush  = 1'b0;
      i_rdy    = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_outputs", 0, 0, 3'd0, 24'h0, 64'h0, 0);
      checkRdy("reset_rdy", 1'b1);
      rst_n = 1'b1;
      stepIdle();

      // 020 / 021 two-parcel Ai forms
      applyStimulus(mkParcel(7'o020, 3'd1, 3'd3, 3'd5), '0);
      checkOutput("op020_first_parcel", 0, 0, 3'd0, 24'h0, 64'h0, 0);
      applyStimulus(16'h1234, '0);
      checkOutput("op020_result", 1, 0, 3'd1, 24'h1D1234, 64'h0, 0);
      stepIdle();
      checkOutput("op020_drained", 0, 0, 3'd1, 24'h1D1234, 64'h0, 0);
      applyStimulus(mkParcel(7'o021, 3'd2, 3'd3, 3'd5), '0);
      applyStimulus(16'h1234, '0);
      checkOutput("op021_result", 1, 0, 3'd2, 24'hE2EDCB, 64'h0, 0);
      stepIdle();

      // 043 / 042 mask forms, back to back
      applyStimulus(mkParcel(7'o043, 3'd3, 3'd0, 3'd4), '0);
`ifdef IMM_MASK_EN
      checkOutput("op043_jk4", 1, 1, 3'd3, 24'h0, 64'hF000000000000000, 0);
`else
      checkOutput("op043_jk4_ill", 1, 0, 3'd3, 24'h0, 64'h0, 1);
`endif
      applyStimulus(mkParcel(7'o042, 3'd4, 3'd0, 3'd4), '0);
`ifdef IMM_MASK_EN
      checkOutput("op042_jk4", 1, 1, 3'd4, 24'h0, 64'h0FFFFFFFFFFFFFFF, 0);
`else
      checkOutput("op042_jk4_ill", 1, 0, 3'd4, 24'h0, 64'h0, 1);
`endif
      applyStimulus(mkParcel(7'o043, 3'd5, 3'd0, 3'd0), '0);
`ifdef IMM_MASK_EN
      checkOutput("op043_jk0", 1, 1, 3'd5, 24'h0, 64'h0, 0);
`else
      checkOutput("op043_jk0_ill", 1, 0, 3'd5, 24'h0, 64'h0, 1);
`endif
      applyStimulus(mkParcel(7'o042, 3'd6, 3'd0, 3'd0), '0);
`ifdef IMM_MASK_EN
      checkOutput("op042_jk0", 1, 1, 3'd6, 24'h0, 64'hFFFFFFFFFFFFFFFF, 0);
`else
      checkOutput("op042_jk0_ill", 1, 0, 3'd6, 24'h0, 64'h0, 1);
`endif

      // 023 / 022 one-parcel Ai forms
      applyStimulus(mkParcel(7'o023, 3'd4, 3'd1, 3'd1), 64'hDEADBEEF_CAFEF00D);
      checkOutput("op023_sj", 1, 0, 3'd4, 24'hFEF00D, 64'h0, 0);
      applyStimulus(mkParcel(7'o022, 3'd5, 3'd7, 3'd7), '0);
      checkOutput("op022_jk77", 1, 0, 3'd5, 24'h00003F, 64'h0, 0);
      stepIdle();

      // 040 / 041 two-parcel Si forms
      applyStimulus(mkParcel(7'o040, 3'd6, 3'd1, 3'd2), '0);
      applyStimulus(16'hABCD, '0);
      checkOutput("op040_result", 1, 1, 3'd6, 24'h0, 64'h00000000000AABCD, 0);
      applyStimulus(mkParcel(7'o041, 3'd7, 3'd1, 3'd2), '0);
      applyStimulus(16'hABCD, '0);
      checkOutput("op041_result", 1, 1, 3'd7, 24'h0, 64'hFFFFFFFFFFF55432, 0);
      stepIdle();

      // Backpressure: result holds, next parcel waits, then drains and loads together
      i_rdy = 1'b0;
      applyStimulus(mkParcel(7'o022, 3'd7, 3'd1, 3'd1), '0);
      i_p_vld  = 1'b1;
      i_parcel = mkParcel(7'o022, 3'd0, 3'd2, 3'd0);
      for (int c = 0; c < 5; c++) begin
         checkOutput($sformatf("bp_hold_%0d", c), 1, 0, 3'd7, 24'h000009, 64'h0, 0);
         checkRdy($sformatf("bp_rdy_low_%0d", c), 1'b0);
         @(posedge clk);
         #1;
      end
      i_rdy = 1'b1;
      #1;
      checkRdy("bp_rdy_high", 1'b1);
      @(posedge clk);
      #1;
      i_p_vld = 1'b0;
      checkOutput("bp_drain_and_load", 1, 0, 3'd0, 24'h000010, 64'h0, 0);
      stepIdle();
      checkOutput("bp_final_drain", 0, 0, 3'd0, 24'h000010, 64'h0, 0);

      // Flush in WAIT_M: the partial 040 is lost and the next parcel is an opcode
      applyStimulus(mkParcel(7'o040, 3'd1, 3'd0, 3'd0), '0);
      i_flush = 1'b1;
      applyStimulus(mkParcel(7'o022, 3'd1, 3'd1, 3'd1), '0);
      i_flush = 1'b0;
      checkOutput("flush_no_result", 0, 0, 3'd0, 24'h000010, 64'h0, 0);
      applyStimulus(mkParcel(7'o022, 3'd2, 3'd3, 3'd4), '0);
      checkOutput("flush_next_is_opcode", 1, 0, 3'd2, 24'h00001C, 64'h0, 0);

      // Flush also drops a pending result held by backpressure
      i_rdy   = 1'b0;
      i_flush = 1'b1;
      stepIdle();
      i_flush = 1'b0;
      i_rdy   = 1'b1;
      checkOutput("flush_drops_pending", 0, 0, 3'd2, 24'h00001C, 64'h0, 0);

      // Reset pulse in WAIT_M
      applyStimulus(mkParcel(7'o041, 3'd3, 3'd2, 3'd2), '0);
      rst_n = 1'b0;
      #2;
      checkOutput("midreset_outputs", 0, 0, 3'd0, 24'h0, 64'h0, 0);
      checkRdy("midreset_rdy", 1'b1);
      rst_n = 1'b1;
      stepIdle();
      checkOutput("midreset_no_result", 0, 0, 3'd0, 24'h0, 64'h0, 0);
      applyStimulus(mkParcel(7'o022, 3'd5, 3'd0, 3'd1), '0);
      checkOutput("midreset_next_is_opcode", 1, 0, 3'd5, 24'h000001, 64'h0, 0);
      stepIdle();

      // Illegal opcode
      applyStimulus(mkParcel(7'o077, 3'd4, 3'd7, 3'd7), 64'hFFFFFFFFFFFFFFFF);
      checkOutput("op077_illegal", 1, 0, 3'd4, 24'h0, 64'h0, 1);
      stepIdle();
      checkOutput("op077_drained", 0, 0, 3'd4, 24'h0, 64'h0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
